// File: rtl/sdfa_layer_sequencer.sv
// sdfa_layer_sequencer: walks cfg_layers x cfg_tiles tiles during the
// processing phase. For each tile it waits for the input buffers, fires a
// one-cycle tile_start into the block array and waits for blk_done.
//
// Interface semantics: cfg_valid, blk_done and abort are single-cycle strobes
// sampled on the rising clk edge. start and in_filled are levels, sampled
// only in ARMED and FILL respectively. tile_start, layer_done and cfg_err are
// registered one-cycle pulses. busy and all_done are registered levels.
// No backpressure exists on any signal.
module sdfa_layer_sequencer #(
  parameter int LAYER_W = 3,
  parameter int TILE_W  = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cfg_valid,
  input  logic [LAYER_W-1:0] cfg_layers,
  input  logic [TILE_W-1:0]  cfg_tiles,
  input  logic               start,
  input  logic               in_filled,
  input  logic               blk_done,
  input  logic               abort,
  output logic               tile_start,
  output logic [LAYER_W-1:0] layer_idx,
  output logic [TILE_W-1:0]  tile_idx,
  output logic               busy,
  output logic               layer_done,
  output logic               all_done,
  output logic               cfg_err,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_FILL  = 3'd2,
    S_ISSUE = 3'd3,
    S_RUN   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             r_state;
  logic [LAYER_W-1:0] r_cfg_layers;
  logic [TILE_W-1:0]  r_cfg_tiles;
  logic [LAYER_W-1:0] r_layer_idx;
  logic [TILE_W-1:0]  r_tile_idx;
  logic               r_tile_start;
  logic               r_layer_done;
  logic               r_cfg_err;
  logic               r_busy;
  logic               r_all_done;

  state_t             w_state_nxt;
  logic [LAYER_W-1:0] w_cfg_layers_nxt;
  logic [TILE_W-1:0]  w_cfg_tiles_nxt;
  logic [LAYER_W-1:0] w_layer_nxt;
  logic [TILE_W-1:0]  w_tile_nxt;
  logic               w_tile_start_nxt;
  logic               w_layer_done_nxt;
  logic               w_cfg_err_nxt;
  logic               w_cfg_ok;
  logic               w_last_tile;
  logic               w_last_layer;

  assign w_cfg_ok     = (cfg_layers != '0) && (cfg_tiles != '0);
  assign w_last_tile  = (r_tile_idx == r_cfg_tiles - TILE_W'(1));
  assign w_last_layer = (r_layer_idx == r_cfg_layers - LAYER_W'(1));

  // Next-state, index and pulse decode; abort outranks every other event.
  always_comb begin
    w_state_nxt      = r_state;
    w_cfg_layers_nxt = r_cfg_layers;
    w_cfg_tiles_nxt  = r_cfg_tiles;
    w_layer_nxt      = r_layer_idx;
    w_tile_nxt       = r_tile_idx;
    w_tile_start_nxt = 1'b0;
    w_layer_done_nxt = 1'b0;
    w_cfg_err_nxt    = 1'b0;
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_layer_nxt = '0;
      w_tile_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (cfg_valid) begin
            if (w_cfg_ok) begin
              w_cfg_layers_nxt = cfg_layers;
              w_cfg_tiles_nxt  = cfg_tiles;
              w_layer_nxt      = '0;
              w_tile_nxt       = '0;
              w_state_nxt      = S_ARMED;
            end else begin
              w_cfg_err_nxt = 1'b1;
              if (r_state == S_DONE) begin
                w_state_nxt = S_IDLE;
                w_layer_nxt = '0;
                w_tile_nxt  = '0;
              end
            end
          end
        end
        S_ARMED: begin
          w_cfg_err_nxt = cfg_valid;
          if (start) w_state_nxt = S_FILL;
        end
        S_FILL: begin
          w_cfg_err_nxt = cfg_valid;
          if (in_filled) w_state_nxt = S_ISSUE;
        end
        S_ISSUE: begin
          w_cfg_err_nxt    = cfg_valid;
          w_tile_start_nxt = 1'b1;
          w_state_nxt      = S_RUN;
        end
        S_RUN: begin
          w_cfg_err_nxt = cfg_valid;
          if (blk_done) begin
            if (!w_last_tile) begin
              w_tile_nxt  = r_tile_idx + TILE_W'(1);
              w_state_nxt = S_FILL;
            end else if (!w_last_layer) begin
              w_tile_nxt       = '0;
              w_layer_nxt      = r_layer_idx + LAYER_W'(1);
              w_layer_done_nxt = 1'b1;
              w_state_nxt      = S_FILL;
            end else begin
              w_layer_done_nxt = 1'b1;
              w_state_nxt      = S_DONE;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, latched configuration, indices and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_cfg_layers <= '0;
      r_cfg_tiles  <= '0;
      r_layer_idx  <= '0;
      r_tile_idx   <= '0;
      r_tile_start <= 1'b0;
      r_layer_done <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_busy       <= 1'b0;
      r_all_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cfg_layers <= w_cfg_layers_nxt;
      r_cfg_tiles  <= w_cfg_tiles_nxt;
      r_layer_idx  <= w_layer_nxt;
      r_tile_idx   <= w_tile_nxt;
      r_tile_start <= w_tile_start_nxt;
      r_layer_done <= w_layer_done_nxt;
      r_cfg_err    <= w_cfg_err_nxt;
      r_busy       <= (w_state_nxt == S_FILL) || (w_state_nxt == S_ISSUE) ||
                      (w_state_nxt == S_RUN);
      r_all_done   <= (w_state_nxt == S_DONE);
    end
  end

  assign tile_start = r_tile_start;
  assign layer_idx  = r_layer_idx;
  assign tile_idx   = r_tile_idx;
  assign busy       = r_busy;
  assign layer_done = r_layer_done;
  assign all_done   = r_all_done;
  assign cfg_err    = r_cfg_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_sdfa_layer_sequencer.sv
// Bench for sdfa_layer_sequencer: random layer/tile jobs, config errors,
// abort and mid-run reset, with a scoreboard of expected output events.
module tb_sdfa_layer_sequencer;
  localparam int LAYER_W = 3;
  localparam int TILE_W  = 8;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               cfg_valid = 1'b0;
  logic [LAYER_W-1:0] cfg_layers = '0;
  logic [TILE_W-1:0]  cfg_tiles = '0;
  logic               start = 1'b0;
  logic               in_filled = 1'b0;
  logic               blk_done = 1'b0;
  logic               abort = 1'b0;
  logic               tile_start;
  logic [LAYER_W-1:0] layer_idx;
  logic [TILE_W-1:0]  tile_idx;
  logic               busy;
  logic               layer_done;
  logic               all_done;
  logic               cfg_err;
  logic [2:0]         dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected events: tile_start carries {layer,tile}; layer_done carries the
  // layer_idx visible with the pulse; cfg_err carries the cycle it must hit.
  logic [LAYER_W+TILE_W-1:0] ts_exp_q[$];
  logic [LAYER_W-1:0]        ld_exp_q[$];
  logic [31:0]               ce_exp_q[$];

  sdfa_layer_sequencer #(.LAYER_W(LAYER_W), .TILE_W(TILE_W)) dut (
    .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_layers(cfg_layers),
    .cfg_tiles(cfg_tiles), .start(start), .in_filled(in_filled),
    .blk_done(blk_done), .abort(abort), .tile_start(tile_start),
    .layer_idx(layer_idx), .tile_idx(tile_idx), .busy(busy),
    .layer_done(layer_done), .all_done(all_done), .cfg_err(cfg_err),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare whenever the DUT emits a pulse.
  always @(negedge clk) begin
    if (rstn) begin
      if (cfg_err) begin
        checks++;
        if (ce_exp_q.size() == 0) begin
          errors++;
          $display("FAIL cfg_err_unexpected: got pulse at cycle %0d expected none", cyc);
        end else begin
          logic [31:0] e;
          e = ce_exp_q.pop_front();
          if (e !== cyc) begin
            errors++;
            $display("FAIL cfg_err_cycle: got %0d expected %0d", cyc, e);
          end
        end
      end
      if (tile_start) begin
        checks++;
        if (ts_exp_q.size() == 0) begin
          errors++;
          $display("FAIL tile_start_unexpected: got (%0d,%0d) expected none", layer_idx, tile_idx);
        end else begin
          logic [LAYER_W+TILE_W-1:0] e;
          e = ts_exp_q.pop_front();
          if ({layer_idx, tile_idx} !== e) begin
            errors++;
            $display("FAIL tile_start_idx: got (%0d,%0d) expected (%0d,%0d)",
                     layer_idx, tile_idx, e[LAYER_W+TILE_W-1:TILE_W], e[TILE_W-1:0]);
          end
        end
      end
      if (layer_done) begin
        checks++;
        if (ld_exp_q.size() == 0) begin
          errors++;
          $display("FAIL layer_done_unexpected: got pulse, layer_idx %0d, expected none", layer_idx);
        end else begin
          logic [LAYER_W-1:0] e;
          e = ld_exp_q.pop_front();
          if (layer_idx !== e) begin
            errors++;
            $display("FAIL layer_done_idx: got %0d expected %0d", layer_idx, e);
          end
        end
      end
    end
  end

  // Driver: one-cycle cfg_valid strobe; an error is expected when the
  // sequencer cannot accept (mid-run) or a field is zero.
  task automatic send_cfg(input int l, input int t, input bit may_accept);
    cfg_valid  = 1'b1;
    cfg_layers = LAYER_W'(l);
    cfg_tiles  = TILE_W'(t);
    if (!may_accept || l == 0 || t == 0) ce_exp_q.push_back(cyc + 1);
    step();
    cfg_valid  = 1'b0;
    cfg_layers = LAYER_W'($urandom);
    cfg_tiles  = TILE_W'($urandom);
  endtask

  // Driver + reference model: runs an ARMED job of L layers x T tiles.
  // abort_layer >= 0 aborts on the last blk_done of that layer.
  task automatic run_job(input int L, input int T, input int abort_layer,
                         input bit long_fill, input bit cfg_noise);
    int n;
    int k;
    if (cfg_noise) send_cfg($urandom_range(0, 7), $urandom_range(0, 255), 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int l = 0; l < L; l++) begin
      for (int t = 0; t < T; t++) begin
        n = (long_fill && l == 0 && t == 0) ? 10 : $urandom_range(0, 4);
        for (int i = 0; i < n; i++) begin
          blk_done = ($urandom_range(0, 3) == 0);
          step();
          blk_done = 1'b0;
          check("no_tile_start_in_fill", tile_start, 0);
        end
        in_filled = 1'b1;
        ts_exp_q.push_back({LAYER_W'(l), TILE_W'(t)});
        step();
        check("tile_start_not_early", tile_start, 0);
        in_filled = 1'b0;
        blk_done  = ($urandom_range(0, 1) == 1);
        step();
        blk_done = 1'b0;
        check("tile_start_latency", tile_start, 1);
        check("busy_in_run", busy, 1);
        check("all_done_low_in_run", all_done, 0);
        k = $urandom_range(0, 4);
        for (int i = 0; i < k; i++) begin
          if (cfg_noise && $urandom_range(0, 2) == 0)
            send_cfg($urandom_range(0, 7), $urandom_range(0, 255), 1'b0);
          else
            step();
        end
        blk_done = 1'b1;
        if (t == T - 1 && l == abort_layer) begin
          abort = 1'b1;
          step();
          abort    = 1'b0;
          blk_done = 1'b0;
          check("abort_busy", busy, 0);
          check("abort_layer_idx", layer_idx, 0);
          check("abort_tile_idx", tile_idx, 0);
          check("abort_all_done", all_done, 0);
          return;
        end
        if (t == T - 1) ld_exp_q.push_back(LAYER_W'((l == L - 1) ? l : l + 1));
        step();
        blk_done = 1'b0;
      end
    end
    check("done_all_done", all_done, 1);
    check("done_busy", busy, 0);
    check("done_layer_idx", layer_idx, L - 1);
    check("done_tile_idx", tile_idx, T - 1);
  endtask

  // Main stimulus sequence.
  initial begin
    int L;
    int T;
    repeat (3) step();
    check("rst_tile_start", tile_start, 0);
    check("rst_busy", busy, 0);
    check("rst_all_done", all_done, 0);
    check("rst_layer_done", layer_done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_idx", {layer_idx, tile_idx}, 0);
    check("rst_state", dbg_state, 0);
    rstn = 1'b1;
    step();

    // Rejected configurations in IDLE, then start without a config.
    send_cfg(1, 0, 1'b1);
    step();
    check("bad_cfg_busy", busy, 0);
    send_cfg(0, 5, 1'b1);
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    check("start_in_idle_ignored", busy, 0);

    // Single tile with a long FILL wait.
    send_cfg(1, 1, 1'b1);
    run_job(1, 1, -1, 1'b1, 1'b0);

    // 2x3 job from DONE, with config noise during the run.
    send_cfg(2, 3, 1'b1);
    check("rearm_clears_all_done", all_done, 0);
    run_job(2, 3, -1, 1'b0, 1'b1);

    // Invalid config from DONE drops to IDLE.
    send_cfg(2, 0, 1'b1);
    check("done_bad_cfg_all_done", all_done, 0);
    check("done_bad_cfg_busy", busy, 0);

    // Abort coincident with the last blk_done of layer 0; start must not rearm.
    send_cfg(3, 4, 1'b1);
    run_job(3, 4, 0, 1'b0, 1'b0);
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    check("abort_needs_reload", busy, 0);

    // Random jobs.
    for (int j = 0; j < 5; j++) begin
      L = $urandom_range(1, 7);
      T = $urandom_range(1, 5);
      send_cfg(L, T, 1'b1);
      run_job(L, T, -1, 1'b0, ($urandom_range(0, 1) == 1));
    end

    // Reset asserted mid-RUN.
    send_cfg(2, 2, 1'b1);
    start = 1'b1;
    step();
    start     = 1'b0;
    in_filled = 1'b1;
    ts_exp_q.push_back({LAYER_W'(0), TILE_W'(0)});
    step();
    in_filled = 1'b0;
    repeat (2) step();
    check("pre_reset_busy", busy, 1);
    rstn = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_outputs", {tile_start, layer_done, all_done, cfg_err}, 0);
    check("midrst_idx", {layer_idx, tile_idx}, 0);
    step();
    rstn = 1'b1;
    step();
    check("post_reset_busy", busy, 0);

    repeat (3) step();
    check("ts_queue_empty", ts_exp_q.size(), 0);
    check("ld_queue_empty", ld_exp_q.size(), 0);
    check("ce_queue_empty", ce_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
